// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Opcode field position and the HALT encoding live here.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        HALT
    } fetch_state_t;

    localparam logic [3:0] HALT_OPC = 4'b1111;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
// A cycle with no load and no hold inserts a bubble.
module ifid_reg #(
    parameter int IW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [IW-1:0] instr_i,
    input  logic [AW-1:0] pc_plus_i,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] pc_plus_o,
    output logic          valid_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_o   <= '0;
            pc_plus_o <= '0;
            valid_o   <= 1'b0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
        end else if (en_i) begin
            if (load_i) begin
                instr_o   <= instr_i;
                pc_plus_o <= pc_plus_i;
                valid_o   <= 1'b1;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, skid buffer,
// branch redirect with wrong-path discard, and HALT detection.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]  HALT_OPC = fetch_pkg::HALT_OPC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  branchTarget,
    input  logic               stallF,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemRdata,
    output logic [INSTR_W-1:0] instrD,
    output logic [ADDR_W-1:0]  pcPlusD,
    output logic               validD,
    output logic               halted
);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pcF_q, pcF_d;
    logic [ADDR_W-1:0]   savedTgt_q, savedTgt_d;
    logic                redirPend_q, redirPend_d;
    logic                bufValid_q, bufValid_d;
    logic [INSTR_W-1:0]  buf_q, buf_d;
    logic [ADDR_W-1:0]   pc_plus;
    logic                ld;
    logic [INSTR_W-1:0]  ld_instr;

    assign pc_plus  = pcF_q + ADDR_W'(PC_STEP);
    assign imemReq  = (state_q == REQ);
    assign imemAddr = pcF_q;
    assign halted   = (state_q == HALT);

    function automatic logic is_halt(input logic [INSTR_W-1:0] ins);
        return ins[INSTR_W-1 -: OPC_W] == HALT_OPC;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pcF_q       <= RESET_PC;
            savedTgt_q  <= '0;
            redirPend_q <= 1'b0;
            bufValid_q  <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            savedTgt_q  <= savedTgt_d;
            redirPend_q <= redirPend_d;
            bufValid_q  <= bufValid_d;
            buf_q       <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pcF_d       = pcF_q;
        savedTgt_d  = savedTgt_q;
        redirPend_d = redirPend_q;
        bufValid_d  = bufValid_q;
        buf_d       = buf_q;
        ld          = 1'b0;
        ld_instr    = imemRdata;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imemAck) begin
                    // Wrong-path data: drop it and refetch at the target.
                    if (PCSrc || redirPend_q) begin
                        pcF_d       = PCSrc ? branchTarget : savedTgt_q;
                        redirPend_d = 1'b0;
                    end else if (stallF) begin
                        bufValid_d = 1'b1;
                        buf_d      = imemRdata;
                        state_d    = HOLD;
                    end else begin
                        ld      = 1'b1;
                        pcF_d   = pc_plus;
                        state_d = is_halt(imemRdata) ? HALT : REQ;
                    end
                end else if (PCSrc) begin
                    redirPend_d = 1'b1;
                    savedTgt_d  = branchTarget;
                end
            end
            HOLD: begin
                ld_instr = buf_q;
                if (PCSrc) begin
                    bufValid_d = 1'b0;
                    pcF_d      = branchTarget;
                    state_d    = REQ;
                end else if (!stallF && bufValid_q) begin
                    ld         = 1'b1;
                    pcF_d      = pc_plus;
                    bufValid_d = 1'b0;
                    state_d    = is_halt(buf_q) ? HALT : REQ;
                end
            end
            HALT: begin
                if (PCSrc) begin
                    pcF_d   = branchTarget;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ifid_reg #(
        .IW(INSTR_W),
        .AW(ADDR_W)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (~stallF),
        .clr_i    (PCSrc),
        .load_i   (ld),
        .instr_i  (ld_instr),
        .pc_plus_i(pc_plus),
        .instr_o  (instrD),
        .pc_plus_o(pcPlusD),
        .valid_o  (validD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model checks request
// addresses, IF/ID monitor checks every newly delivered instruction.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCSrc = 1'b0;
    logic        stallF = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic [31:0] instrD;
    logic [31:0] pcPlusD;
    logic        validD;
    logic        halted;

    logic        mem_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] addr0 = '0;
    logic        stall_seen = 1'b0;
    bit          mem_en = 1'b1;
    int          lat = 1;
    int          lat_cur = 1;
    int          cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_del[$];

    assign imemAck   = mem_ack | man_ack;
    assign imemRdata = man_ack ? 32'hDEADBEEF : mem_rdata;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .branchTarget(branchTarget),
        .stallF      (stallF),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemRdata   (imemRdata),
        .instrD      (instrD),
        .pcPlusD     (pcPlusD),
        .validD      (validD),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a == 32'h20) ? {4'hF, a[27:0]} : {4'h1, a[27:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input logic [31:0] a);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (imemReq && imemAddr == a) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_req: no request at %h, addr=%h", a, imemAddr);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},    {31'd0, imemReq}, 32'd0);
        check({tag, "_addr"},   imemAddr, 32'd0);
        check({tag, "_instr"},  instrD, 32'd0);
        check({tag, "_pcplus"}, pcPlusD, 32'd0);
        check({tag, "_valid"},  {31'd0, validD}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    task automatic push_del(input logic [31:0] a);
        exp_del.push_back({instr_of(a), a + 32'd4});
    endtask

    // Memory model: ack after lat cycles of request, checks the address.
    always @(negedge clk) begin
        if (!reset || !mem_en) begin
            cnt     = 0;
            mem_ack = 1'b0;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end
            if (imemReq) begin
                cnt++;
                if (cnt == 1) begin
                    lat_cur = lat;
                    addr0   = imemAddr;
                end else begin
                    check("addr_stable", imemAddr, addr0);
                end
                if (cnt > lat_cur) begin
                    mem_ack   = 1'b1;
                    mem_rdata = instr_of(imemAddr);
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ack_addr: unexpected req %h", imemAddr);
                    end else begin
                        check("ack_addr", imemAddr, exp_addr.pop_front());
                    end
                end
            end
        end
    end

    always @(posedge clk) stall_seen <= stallF;

    // IF/ID monitor: a valid entry not held by a stall is a new delivery.
    always @(negedge clk) begin
        if (reset && validD && !stall_seen) begin
            if (exp_del.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver: unexpected instr %h", instrD);
            end else begin
                logic [63:0] e;
                e = exp_del.pop_front();
                check("instrD", instrD, e[63:32]);
                check("pcPlusD", pcPlusD, e[31:0]);
            end
        end
    end

    initial begin
        repeat (3) tick();
        check_reset("por");
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        push_del(32'h0);
        push_del(32'h4);
        push_del(32'h8);
        reset = 1'b1;

        wait_req(32'h8);
        stallF = 1'b1;
        tick();
        tick();
        check("hold_req", {31'd0, imemReq}, 32'd0);
        check("hold_instr", instrD, instr_of(32'h4));
        check("hold_pcplus", pcPlusD, 32'h8);
        check("hold_valid", {31'd0, validD}, 32'd1);
        tick();
        tick();
        check("hold_req2", {31'd0, imemReq}, 32'd0);
        exp_addr.push_back(32'hC);
        push_del(32'hC);
        stallF = 1'b0;

        wait_req(32'hC);
        wait_req(32'h10);
        exp_addr.push_back(32'h10);
        exp_addr.push_back(32'h40);
        lat = 3;
        PCSrc = 1'b1;
        branchTarget = 32'h40;
        tick();
        PCSrc = 1'b0;
        lat = 1;
        check("redir_addr_hold", imemAddr, 32'h10);
        check("redir_req_hold", {31'd0, imemReq}, 32'd1);
        push_del(32'h40);
        wait_req(32'h40);
        check("discard_valid", {31'd0, validD}, 32'd0);

        exp_addr.push_back(32'h44);
        exp_addr.push_back(32'h20);
        wait_req(32'h44);
        check("pre_flush_valid", {31'd0, validD}, 32'd1);
        stallF = 1'b1;
        PCSrc = 1'b1;
        branchTarget = 32'h20;
        tick();
        check("flush_valid", {31'd0, validD}, 32'd0);
        stallF = 1'b0;
        PCSrc = 1'b0;

        push_del(32'h20);
        wait_req(32'h20);
        tick();
        tick();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_req", {31'd0, imemReq}, 32'd0);
        check("halt_valid", {31'd0, validD}, 32'd1);
        repeat (5) tick();
        check("halt_flag_hold", {31'd0, halted}, 32'd1);
        check("halt_req_hold", {31'd0, imemReq}, 32'd0);
        check("halt_bubble", {31'd0, validD}, 32'd0);
        lat = 5;
        PCSrc = 1'b1;
        branchTarget = 32'h0;
        tick();
        PCSrc = 1'b0;
        check("unhalt_flag", {31'd0, halted}, 32'd0);
        check("unhalt_req", {31'd0, imemReq}, 32'd1);
        check("unhalt_addr", imemAddr, 32'h0);

        tick();
        mem_en = 1'b0;
        reset = 1'b0;
        #1;
        check_reset("midreq");
        tick();
        tick();
        reset = 1'b1;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check("late_ack_req", {31'd0, imemReq}, 32'd1);
        check("late_ack_addr", imemAddr, 32'h0);
        check("late_ack_valid", {31'd0, validD}, 32'd0);
        exp_addr.push_back(32'h0);
        push_del(32'h0);
        lat = 1;
        mem_en = 1'b1;

        for (int i = 0; i < 40; i++) begin
            tick();
            if (exp_addr.size() == 0 && exp_del.size() == 0) break;
        end
        if (exp_addr.size() != 0 || exp_del.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: addr_left=%0d del_left=%0d",
                     exp_addr.size(), exp_del.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
